// File: rtl/num_render_if.sv
// Raster, value and font-ROM signals shared between num_render and its integrator.
// The slave modport is the renderer's view; master is the driving side.
interface num_render_if #(
  parameter int VAL_W = 14
);
  logic             frame_start;
  logic [VAL_W-1:0] value;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             video_on;
  logic [3:0]       font_digit;
  logic [3:0]       font_row;
  logic [11:0]      font_pixels;
  logic             pixel_on;
  logic             busy;

  modport master (
    output frame_start, value, h_cnt, v_cnt, video_on, font_pixels,
    input  font_digit, font_row, pixel_on, busy
  );

  modport slave (
    input  frame_start, value, h_cnt, v_cnt, video_on, font_pixels,
    output font_digit, font_row, pixel_on, busy
  );
endinterface

// File: rtl/num_render.sv
// Decimal readout: double-dabble conversion once per frame, then a 2-stage raster/font pipeline.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits (LSD always shown).
module num_render #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14,
  parameter int X0         = 0,
  parameter int Y0         = 0
) (
  input logic         clk,
  input logic         rst,
  num_render_if.slave bus
);
  localparam int BW      = 4 * NUM_DIGITS;
  localparam int CW      = $clog2(VAL_W + 1);
  localparam int FIELD_W = 12 * NUM_DIGITS;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [VAL_W-1:0] SAT = VAL_W'(pow10(NUM_DIGITS) - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state, state_nx;
  logic             busy_w;
  logic [BW-1:0]    bcd, bcd_adj, bcd_sh, disp;
  logic [VAL_W-1:0] bin, bin_sh;
  logic [CW-1:0]    iter;
  logic             last_iter;

  assign last_iter = (iter == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.frame_start) state_nx = CONV;
      CONV:    if (!bus.frame_start && last_iter) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_w = (state == CONV);
  end

  assign bus.busy = busy_w;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[BW-2:0], bin[VAL_W-1]};
    bin_sh = {bin[VAL_W-2:0], 1'b0};
  end

  // A new frame_start always wins, so an aborted run never reaches disp.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd  <= '0;
      bin  <= '0;
      iter <= '0;
      disp <= '0;
    end else if (bus.frame_start) begin
      bin  <= (bus.value > SAT) ? SAT : bus.value;
      bcd  <= '0;
      iter <= CW'(VAL_W);
    end else if (state == CONV) begin
      bcd  <= bcd_sh;
      bin  <= bin_sh;
      iter <= iter - CW'(1);
      if (last_iter) disp <= bcd_sh;
    end
  end

  // Raster mapping; an unsigned wrap makes h_cnt < X0 / v_cnt < Y0 fall outside.
  logic [11:0] dx, dy;
  logic        in_box;
  logic [2:0]  k;
  logic [3:0]  col, row, cur_digit;
  logic        cur_blank;

  assign dx     = {2'b00, bus.h_cnt} - 12'(X0);
  assign dy     = {2'b00, bus.v_cnt} - 12'(Y0);
  assign in_box = (dx < 12'(FIELD_W)) && (dy < 12'd16);
  assign row    = 4'(dy);

  always_comb begin
    k   = 3'd0;
    col = 4'(dx);
    for (int j = 1; j < NUM_DIGITS; j++) begin
      if (dx >= 12'(12 * j)) begin
        k   = 3'(j);
        col = 4'(dx - 12'(12 * j));
      end
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (k == 3'(j)) cur_digit = disp[4*(NUM_DIGITS-1-j) +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    logic zp;
    zp        = 1'b1;
    lead_zero = '0;
    for (int j = 0; j < NUM_DIGITS - 1; j++) begin
      zp           = zp & (disp[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      lead_zero[j] = zp;
    end
    cur_blank = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (k == 3'(j)) cur_blank = lead_zero[j];
    end
  end
`else
  always_comb begin
    cur_blank = 1'b0;
  end
`endif

  logic [3:0] font_digit_q, font_row_q, col_d;
  logic       in_box_d, video_on_d, blank_d, pixel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      font_digit_q <= 4'd0;
      font_row_q   <= 4'd0;
      col_d        <= 4'd0;
      in_box_d     <= 1'b0;
      video_on_d   <= 1'b0;
      blank_d      <= 1'b0;
      pixel_q      <= 1'b0;
    end else begin
      font_digit_q <= in_box ? cur_digit : 4'd0;
      font_row_q   <= in_box ? row : 4'd0;
      col_d        <= in_box ? col : 4'd0;
      in_box_d     <= in_box;
      video_on_d   <= bus.video_on;
      blank_d      <= in_box & cur_blank;
      pixel_q      <= in_box_d & video_on_d & ~blank_d & bus.font_pixels[4'd11 - col_d];
    end
  end

  assign bus.font_digit = font_digit_q;
  assign bus.font_row   = font_row_q;
  assign bus.pixel_on   = pixel_q;
endmodule
